hci_dm_cfg_sequencer: RTL and testbench

// Hardware master for the hwpe-ctrl peripheral port of an HCI datamover. Sits directly upstream of the datamover slave port.

---
 rtl/hci_dm_cfg_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hci_dm_cfg_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_dm_cfg_sequencer.sv
// Periph-bus master that programs one HCI datamover job per descriptor:
// acquire, eleven job-register writes, trigger, then status polling until idle.
module hci_dm_cfg_sequencer #(
    parameter int unsigned          ID_PERIPH        = 2,
    parameter logic [ID_PERIPH-1:0] MY_ID            = '0,
    parameter logic [31:0]          REG_TRIGGER_OFFS = 32'h00,
    parameter logic [31:0]          REG_ACQUIRE_OFFS = 32'h04,
    parameter logic [31:0]          REG_STATUS_OFFS  = 32'h0C,
    parameter logic [31:0]          REG_JOB_OFFS     = 32'h40,
    parameter int unsigned          POLL_GAP         = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [31:0]          desc_base_i,
    input  logic [10:0][31:0]    desc_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          job_id_o,
    output logic                 periph_req_o,
    input  logic                 periph_gnt_i,
    output logic [31:0]          periph_add_o,
    output logic                 periph_wen_o,
    output logic [3:0]           periph_be_o,
    output logic [31:0]          periph_data_o,
    output logic [ID_PERIPH-1:0] periph_id_o,
    input  logic [31:0]          periph_r_data_i,
    input  logic                 periph_r_valid_i,
    input  logic [ID_PERIPH-1:0] periph_r_id_i
);
    localparam int unsigned   NWORDS     = 11;
    localparam logic [3:0]    LAST_K     = 4'(NWORDS - 1);
    localparam int unsigned   CW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW-1:0] GAP_RELOAD = CW'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ,
        S_ACQ_WAIT,
        S_JOB,
        S_TRIG,
        S_POLL_WAIT,
        S_STAT,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [3:0]              k_q;
    logic [CW-1:0]           gap_q;
    logic [31:0]             base_q;
    logic [10:0][31:0]       words_q;
    logic                    req_q;
    logic [31:0]             add_q;
    logic                    wen_q;
    logic [3:0]              be_q;
    logic [31:0]             data_q;
    logic                    wait_rsp_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic [31:0]             job_id_q;

    logic                    rsp_ok;
    logic [3:0]              k_d;
    logic [31:0]             job_add_d;

    // wait_rsp_q only rises after the grant edge, so a response coincident with the grant is never taken
    assign rsp_ok    = wait_rsp_q && periph_r_valid_i && (periph_r_id_i == MY_ID);
    assign k_d       = k_q + 4'd1;
    assign job_add_d = base_q + REG_JOB_OFFS + {26'd0, k_d, 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            gap_q      <= '0;
            base_q     <= '0;
            words_q    <= '0;
            req_q      <= 1'b0;
            add_q      <= '0;
            wen_q      <= 1'b1;
            be_q       <= '0;
            data_q     <= '0;
            wait_rsp_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            job_id_q   <= '0;
        end else begin
            if (req_q && periph_gnt_i) begin
                req_q      <= 1'b0;
                be_q       <= '0;
                wait_rsp_q <= 1'b1;
            end
            if (rsp_ok) begin
                wait_rsp_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (desc_valid_i && ready_q) begin
                        base_q  <= desc_base_i;
                        words_q <= desc_words_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        be_q    <= 4'hF;
                        wen_q   <= 1'b1;
                        add_q   <= desc_base_i + REG_ACQUIRE_OFFS;
                        data_q  <= '0;
                        state_q <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (rsp_ok) begin
                        // bit 31 set means the datamover is still owned by another master
                        if (periph_r_data_i[31]) begin
                            gap_q   <= GAP_RELOAD;
                            state_q <= S_ACQ_WAIT;
                        end else begin
                            job_id_q <= periph_r_data_i;
                            k_q      <= '0;
                            req_q    <= 1'b1;
                            be_q     <= 4'hF;
                            wen_q    <= 1'b0;
                            add_q    <= base_q + REG_JOB_OFFS;
                            data_q   <= words_q[0];
                            state_q  <= S_JOB;
                        end
                    end
                end
                S_ACQ_WAIT: begin
                    if (gap_q == '0) begin
                        req_q   <= 1'b1;
                        be_q    <= 4'hF;
                        wen_q   <= 1'b1;
                        add_q   <= base_q + REG_ACQUIRE_OFFS;
                        state_q <= S_ACQ;
                    end else begin
                        gap_q <= gap_q - CW'(1);
                    end
                end
                S_JOB: begin
                    if (rsp_ok) begin
                        req_q <= 1'b1;
                        be_q  <= 4'hF;
                        if (k_q == LAST_K) begin
                            add_q   <= base_q + REG_TRIGGER_OFFS;
                            data_q  <= '0;
                            state_q <= S_TRIG;
                        end else begin
                            k_q    <= k_d;
                            add_q  <= job_add_d;
                            data_q <= words_q[k_d];
                        end
                    end
                end
                S_TRIG: begin
                    if (rsp_ok) begin
                        gap_q   <= GAP_RELOAD;
                        state_q <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (gap_q == '0) begin
                        req_q   <= 1'b1;
                        be_q    <= 4'hF;
                        wen_q   <= 1'b1;
                        add_q   <= base_q + REG_STATUS_OFFS;
                        state_q <= S_STAT;
                    end else begin
                        gap_q <= gap_q - CW'(1);
                    end
                end
                S_STAT: begin
                    if (rsp_ok) begin
                        if (periph_r_data_i[0]) begin
                            gap_q   <= GAP_RELOAD;
                            state_q <= S_POLL_WAIT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign desc_ready_o  = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign job_id_o      = job_id_q;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_be_o   = be_q;
    assign periph_data_o = data_q;
    assign periph_id_o   = MY_ID;

endmodule

// File: tb/tb_hci_dm_cfg_sequencer.sv
// Bench for hci_dm_cfg_sequencer: a periph slave with random grant/response timing,
// checked against a transaction-level prediction of every bus access per job.
module tb_hci_dm_cfg_sequencer;
    localparam int unsigned ID_PERIPH  = 2;
    localparam logic [1:0]  MY_ID      = 2'd1;
    localparam logic [1:0]  FOREIGN_ID = 2'd2;
    localparam int          POLL_GAP   = 8;
    localparam logic [31:0] OFFS_TRIG  = 32'h00;
    localparam logic [31:0] OFFS_ACQ   = 32'h04;
    localparam logic [31:0] OFFS_STAT  = 32'h0C;
    localparam logic [31:0] OFFS_JOB   = 32'h40;

    logic              clk = 1'b0;
    logic              rst;
    logic              descValid;
    logic              descReady;
    logic [31:0]       descBase;
    logic [10:0][31:0] descWords;
    logic              busy;
    logic              doneOut;
    logic [31:0]       jobId;
    logic              req;
    logic              gnt;
    logic [31:0]       addOut;
    logic              wenOut;
    logic [3:0]        beOut;
    logic [31:0]       dataOut;
    logic [1:0]        idOut;
    logic [31:0]       rData;
    logic              rValid;
    logic [1:0]        rId;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit monOn       = 0;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    txn_t        expQ[$];
    logic [31:0] acqQ[$];
    logic [31:0] statQ[$];
    logic [31:0] curBase;
    logic [31:0] stallAddr;
    int          stallCycles;
    bit          stallUsed;
    int          maxGntDly;
    int          minLat;
    int          maxLat;
    bit          foreignEn;

    hci_dm_cfg_sequencer #(
        .ID_PERIPH (ID_PERIPH),
        .MY_ID     (MY_ID),
        .POLL_GAP  (POLL_GAP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .desc_valid_i     (descValid),
        .desc_ready_o     (descReady),
        .desc_base_i      (descBase),
        .desc_words_i     (descWords),
        .busy_o           (busy),
        .done_o           (doneOut),
        .job_id_o         (jobId),
        .periph_req_o     (req),
        .periph_gnt_i     (gnt),
        .periph_add_o     (addOut),
        .periph_wen_o     (wenOut),
        .periph_be_o      (beOut),
        .periph_data_o    (dataOut),
        .periph_id_o      (idOut),
        .periph_r_data_i  (rData),
        .periph_r_valid_i (rValid),
        .periph_r_id_i    (rId)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_req"},    32'(req),       32'd0);
        checkOutput({name, "_add"},    addOut,         32'd0);
        checkOutput({name, "_wen"},    32'(wenOut),    32'd1);
        checkOutput({name, "_be"},     32'(beOut),     32'd0);
        checkOutput({name, "_data"},   dataOut,        32'd0);
        checkOutput({name, "_id"},     32'(idOut),     32'(MY_ID));
        checkOutput({name, "_ready"},  32'(descReady), 32'd1);
        checkOutput({name, "_busy"},   32'(busy),      32'd0);
        checkOutput({name, "_done"},   32'(doneOut),   32'd0);
        checkOutput({name, "_job_id"}, jobId,          32'd0);
    endtask

    // Reference: the full ordered list of bus accesses a job must produce, plus the slave's read data.
    task automatic planJob(input logic [31:0] base, input logic [10:0][31:0] words,
                           input int nLocked, input logic [31:0] lockedVal,
                           input logic [31:0] finalAcq, input int nBusy);
        txn_t t;
        expQ.delete();
        acqQ.delete();
        statQ.delete();
        curBase = base;
        for (int i = 0; i <= nLocked; i++) begin
            t.add = base + OFFS_ACQ; t.wen = 1'b1; t.data = '0;
            expQ.push_back(t);
            acqQ.push_back((i < nLocked) ? lockedVal : finalAcq);
        end
        for (int k = 0; k < 11; k++) begin
            t.add = base + OFFS_JOB + 32'(4 * k); t.wen = 1'b0; t.data = words[4'(k)];
            expQ.push_back(t);
        end
        t.add = base + OFFS_TRIG; t.wen = 1'b0; t.data = '0;
        expQ.push_back(t);
        for (int i = 0; i <= nBusy; i++) begin
            t.add = base + OFFS_STAT; t.wen = 1'b1; t.data = '0;
            expQ.push_back(t);
            statQ.push_back((i < nBusy) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFE));
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] base, input logic [10:0][31:0] words,
                                 input int nLocked, input logic [31:0] lockedVal, input logic [31:0] finalAcq,
                                 input int nBusy, input bit checkLen, input bit doAbort, input logic [31:0] abortAddr);
        int  acceptCyc;
        bit  seenDone = 0;
        bit  aborted  = 0;
        planJob(base, words, nLocked, lockedVal, finalAcq, nBusy);
        @(negedge clk);
        descBase  = base;
        descWords = words;
        descValid = 1'b1;
        checkOutput({name, "_ready_at_start"}, 32'(descReady), 32'd1);
        acceptCyc = cyc;
        @(negedge clk);
        // Keep a different descriptor offered while busy: it must be neither taken nor leak into the job.
        descBase = $urandom;
        for (int i = 0; i < 11; i++) descWords[4'(i)] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            if (doneOut) begin seenDone = 1; break; end
            if (doAbort && req && addOut == abortAddr) begin aborted = 1; break; end
            @(negedge clk);
            #1;
        end
        if (doAbort) begin
            checkOutput({name, "_abort_point_reached"}, 32'(aborted), 32'd1);
            rst       = 1'b1;
            descValid = 1'b0;
            @(negedge clk);
            #1;
            checkResetValues({name, "_midjob_rst"});
            rst = 1'b0;
            expQ.delete();
            acqQ.delete();
            statQ.delete();
        end else begin
            checkOutput({name, "_done_seen"}, 32'(seenDone), 32'd1);
            descValid = 1'b0;
            if (seenDone) begin
                checkOutput({name, "_busy_at_done"},  32'(busy),        32'd1);
                checkOutput({name, "_ready_at_done"}, 32'(descReady),   32'd0);
                checkOutput({name, "_job_id"},        jobId,            finalAcq);
                checkOutput({name, "_txn_left"},      32'(expQ.size()), 32'd0);
                if (checkLen) checkOutput({name, "_job_length"}, 32'(cyc - acceptCyc + 1), 32'(POLL_GAP + 30));
                @(negedge clk);
                checkOutput({name, "_done_pulse_end"}, 32'(doneOut),   32'd0);
                checkOutput({name, "_busy_after"},     32'(busy),      32'd0);
                checkOutput({name, "_ready_after"},    32'(descReady), 32'd1);
            end
        end
    endtask

    // Periph slave: grants after a chosen delay, answers after a chosen latency, and
    // optionally sprays responses that the master must ignore.
    initial begin : slave
        int          pendCnt = 0;
        int          waitCnt = 0;
        int          lastAcqRsp = 0;
        int          lastStatRsp = 0;
        bit          holding = 0;
        bit          justGranted = 0;
        bit          acqRetry = 0;
        bit          statRetry = 0;
        bit          outstanding;
        bit          pendIsAcq = 0;
        bit          pendIsStat = 0;
        logic [31:0] pendData = '0;
        txn_t        hold;
        txn_t        e;
        gnt = 1'b0; rValid = 1'b0; rId = MY_ID; rData = '0;
        forever begin
            @(negedge clk);
            gnt = 1'b0; rValid = 1'b0; rId = MY_ID; rData = '0;
            if (rst) begin
                pendCnt = 0; holding = 0; justGranted = 0; acqRetry = 0; statRetry = 0;
            end else begin
                outstanding = (pendCnt > 0);
                if (pendCnt > 0) begin
                    pendCnt--;
                    if (pendCnt == 0) begin
                        rValid = 1'b1;
                        rData  = pendData;
                        if (pendIsAcq)  begin acqRetry  = pendData[31]; lastAcqRsp  = cyc; end
                        if (pendIsStat) begin statRetry = pendData[0];  lastStatRsp = cyc; end
                    end else if (foreignEn) begin
                        rValid = 1'b1; rId = FOREIGN_ID; rData = 32'h8000_0001;
                    end
                end
                if (justGranted) checkOutput("req_drop_after_gnt", 32'(req), 32'd0);
                justGranted = 0;
                if (req) begin
                    checkOutput("one_outstanding", 32'(outstanding), 32'd0);
                    checkOutput("be_while_req",    32'(beOut),       32'hF);
                    checkOutput("id_while_req",    32'(idOut),       32'(MY_ID));
                    if (!holding) begin
                        holding   = 1;
                        hold.add  = addOut;
                        hold.wen  = wenOut;
                        hold.data = dataOut;
                        if (addOut == curBase + OFFS_ACQ && acqRetry) begin
                            checkOutput("acq_retry_gap", 32'((cyc - lastAcqRsp - 1) >= POLL_GAP), 32'd1);
                            acqRetry = 0;
                        end
                        if (addOut == curBase + OFFS_STAT && statRetry) begin
                            checkOutput("stat_poll_gap", 32'((cyc - lastStatRsp - 1) >= POLL_GAP), 32'd1);
                            statRetry = 0;
                        end
                        if (addOut == stallAddr && !stallUsed) begin
                            waitCnt   = stallCycles;
                            stallUsed = 1;
                        end else begin
                            waitCnt = $urandom_range(maxGntDly, 0);
                        end
                    end else begin
                        checkOutput("stall_add_stable",  addOut,       hold.add);
                        checkOutput("stall_wen_stable",  32'(wenOut),  32'(hold.wen));
                        checkOutput("stall_data_stable", dataOut,      hold.data);
                    end
                    if (waitCnt == 0) begin
                        gnt         = 1'b1;
                        holding     = 0;
                        justGranted = 1;
                        checkOutput("txn_expected", 32'(expQ.size() > 0), 32'd1);
                        if (expQ.size() > 0) begin
                            e = expQ.pop_front();
                            checkOutput("txn_add", addOut,      e.add);
                            checkOutput("txn_wen", 32'(wenOut), 32'(e.wen));
                            if (!e.wen) checkOutput("txn_data", dataOut, e.data);
                        end
                        pendIsAcq  = wenOut && (addOut == curBase + OFFS_ACQ);
                        pendIsStat = wenOut && (addOut == curBase + OFFS_STAT);
                        if (pendIsAcq)       pendData = (acqQ.size()  > 0) ? acqQ.pop_front()  : 32'h0;
                        else if (pendIsStat) pendData = (statQ.size() > 0) ? statQ.pop_front() : 32'h0;
                        else                 pendData = $urandom;
                        pendCnt = $urandom_range(maxLat, minLat);
                        if (foreignEn) begin
                            rValid = 1'b1; rId = MY_ID; rData = 32'h8000_0001;
                        end
                    end else begin
                        waitCnt--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (monOn && !rst) begin
                checkOutput("done_ready_exclusive", 32'(doneOut && descReady), 32'd0);
                checkOutput("ready_is_not_busy",    32'(descReady),            32'(!busy));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [10:0][31:0] w;
        logic [31:0]       base;
        rst = 1'b1; descValid = 1'b0; descBase = '0; descWords = '0;
        curBase = '0; stallAddr = '0; stallCycles = 0; stallUsed = 1;
        maxGntDly = 0; minLat = 1; maxLat = 1; foreignEn = 0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst   = 1'b0;
        monOn = 1;

        w = '0;
        w[1] = 32'h4; w[2] = 32'h0000_F00F; w[3] = 32'h0000_F00F; w[4] = 32'h40; w[7] = 32'h4;
        applyStimulus("t1_writes", 32'h100, w, 0, 32'h0, 32'h5, 0, 1, 0, 32'h0);

        applyStimulus("t2_busy_acq", 32'h100, w, 2, 32'hFFFF_FFFF, 32'h3, 0, 0, 0, 32'h0);

        stallAddr = 32'h100 + OFFS_JOB + 32'd16; stallCycles = 5; stallUsed = 0;
        applyStimulus("t3_gnt_stall", 32'h100, w, 0, 32'h0, 32'h7, 0, 0, 0, 32'h0);
        checkOutput("t3_stall_exercised", 32'(stallUsed), 32'd1);

        applyStimulus("t4_status_poll", 32'h2000, w, 0, 32'h0, 32'h9, 4, 0, 0, 32'h0);

        foreignEn = 1; minLat = 3; maxLat = 3;
        applyStimulus("t5_foreign_rsp", 32'h100, w, 1, 32'h8000_0000, 32'h11, 1, 0, 0, 32'h0);
        foreignEn = 0; minLat = 1; maxLat = 1;

        applyStimulus("t6_abort", 32'h100, w, 0, 32'h0, 32'h21, 0, 0, 1, 32'h100 + OFFS_JOB + 32'd24);
        applyStimulus("t6_rerun", 32'h100, w, 0, 32'h0, 32'h22, 0, 1, 0, 32'h0);

        for (int j = 0; j < 6; j++) begin
            base = (j == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
            for (int i = 0; i < 11; i++) w[4'(i)] = $urandom;
            maxGntDly = 2; minLat = 1; maxLat = 3;
            foreignEn = ($urandom_range(1, 0) == 1);
            applyStimulus("rnd", base, w, $urandom_range(2, 0), $urandom | 32'h8000_0000,
                          $urandom & 32'h7FFF_FFFF, $urandom_range(3, 0), 0, 0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
